// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, op classes, immediate formats, FSM states.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } op_class_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_READ, ST_VALID} state_t;

  // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects compressed encodings.
  function automatic op_class_t classify(input logic [31:0] instr);
    case (instr[6:0])
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_OP:     return CLS_OP;
      OPC_FENCE:  return CLS_FENCE;
      OPC_SYSTEM: return CLS_SYSTEM;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic imm_fmt_t fmt_of(input op_class_t cls);
    case (cls)
      CLS_LUI, CLS_AUIPC:                                   return IMM_U;
      CLS_JAL:                                              return IMM_J;
      CLS_BRANCH:                                           return IMM_B;
      CLS_STORE:                                            return IMM_S;
      CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_FENCE, CLS_SYSTEM: return IMM_I;
      default:                                              return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from instr[31].
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register-file selects, captures 1-cycle-latency read data,
// patches operands from the writeback port and hands a decoded bundle to execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [31:0]     pc_i,
  input  logic            flush_i,
  output logic [4:0]      rf_out1_sel_o,
  output logic [4:0]      rf_out2_sel_o,
  input  logic [XLEN-1:0] rf_out1_i,
  input  logic [XLEN-1:0] rf_out2_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_sel_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [31:0]     dec_pc_o,
  output logic [XLEN-1:0] dec_rs1_val_o,
  output logic [XLEN-1:0] dec_rs2_val_o,
  output logic [31:0]     dec_imm_o,
  output logic [4:0]      dec_rd_o,
  output logic [3:0]      dec_op_o,
  output logic [2:0]      dec_funct3_o,
  output logic            dec_funct7b5_o,
  output logic            dec_illegal_o
);

  state_t          r_state;
  logic [31:0]     r_instr;
  logic [31:0]     r_pc;
  logic            r_fwd1_vld;
  logic            r_fwd2_vld;
  logic [XLEN-1:0] r_fwd1_data;
  logic [XLEN-1:0] r_fwd2_data;

  logic            w_ready;
  logic            w_accept;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_wb_live;
  logic            w_acc_hit1;
  logic            w_acc_hit2;
  logic            w_hit1;
  logic            w_hit2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  op_class_t       w_cls;
  imm_fmt_t        w_fmt;
  logic [31:0]     w_imm;
  logic            w_no_rd;

  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_ready  = !reset_i && !flush_i &&
                    ((r_state == ST_EMPTY) || ((r_state == ST_VALID) && dec_ready_i));
  assign w_accept = instr_valid_i && w_ready;

  assign instr_ready_o = w_ready;
  assign rf_out1_sel_o = w_ready ? instr_i[19:15] : w_rs1;
  assign rf_out2_sel_o = w_ready ? instr_i[24:20] : w_rs2;
  assign dec_valid_o   = (r_state == ST_VALID);

  // The register file reads before it writes, so a write landing on the accept edge is
  // invisible in READ and has to be remembered here.
  assign w_wb_live  = FWD_EN && wb_en_i && (wb_sel_i != 5'd0);
  assign w_acc_hit1 = w_wb_live && (wb_sel_i == instr_i[19:15]);
  assign w_acc_hit2 = w_wb_live && (wb_sel_i == instr_i[24:20]);
  assign w_hit1     = w_wb_live && (wb_sel_i == w_rs1);
  assign w_hit2     = w_wb_live && (wb_sel_i == w_rs2);

  assign w_op1 = (w_rs1 == 5'd0) ? '0 :
                 w_hit1          ? wb_data_i :
                 r_fwd1_vld      ? r_fwd1_data : rf_out1_i;
  assign w_op2 = (w_rs2 == 5'd0) ? '0 :
                 w_hit2          ? wb_data_i :
                 r_fwd2_vld      ? r_fwd2_data : rf_out2_i;

  assign w_cls   = classify(r_instr);
  assign w_fmt   = fmt_of(w_cls);
  assign w_no_rd = (w_cls == CLS_BRANCH) || (w_cls == CLS_STORE) ||
                   (w_cls == CLS_FENCE)  || (w_cls == CLS_ILLEGAL);

  imm_gen u_imm_gen (
    .i_instr (r_instr),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state        <= ST_EMPTY;
      r_instr        <= '0;
      r_pc           <= '0;
      r_fwd1_vld     <= 1'b0;
      r_fwd2_vld     <= 1'b0;
      r_fwd1_data    <= '0;
      r_fwd2_data    <= '0;
      dec_pc_o       <= '0;
      dec_rs1_val_o  <= '0;
      dec_rs2_val_o  <= '0;
      dec_imm_o      <= '0;
      dec_rd_o       <= '0;
      dec_op_o       <= '0;
      dec_funct3_o   <= '0;
      dec_funct7b5_o <= 1'b0;
      dec_illegal_o  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr     <= instr_i;
        r_pc        <= pc_i;
        r_fwd1_vld  <= w_acc_hit1;
        r_fwd2_vld  <= w_acc_hit2;
        r_fwd1_data <= wb_data_i;
        r_fwd2_data <= wb_data_i;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_state <= ST_READ;
        end
        ST_READ: begin
          if (flush_i) begin
            r_state <= ST_EMPTY;
          end else begin
            r_state        <= ST_VALID;
            dec_pc_o       <= r_pc;
            dec_rs1_val_o  <= w_op1;
            dec_rs2_val_o  <= w_op2;
            dec_imm_o      <= w_imm;
            dec_rd_o       <= w_no_rd ? 5'd0 : r_instr[11:7];
            dec_op_o       <= w_cls;
            dec_funct3_o   <= r_instr[14:12];
            dec_funct7b5_o <= r_instr[30];
            dec_illegal_o  <= (w_cls == CLS_ILLEGAL);
          end
        end
        ST_VALID: begin
          // Keep the presented operands architecturally current while they wait.
          if (w_hit1) dec_rs1_val_o <= wb_data_i;
          if (w_hit2) dec_rs2_val_o <= wb_data_i;
          if (flush_i)          r_state <= ST_EMPTY;
          else if (w_accept)    r_state <= ST_READ;
          else if (dec_ready_i) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: register-file model, transaction model and directed vectors.
`timescale 1ns/1ps
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  rf_out1_sel_o, rf_out2_sel_o;
  logic [31:0] rf_out1_i, rf_out2_i;
  logic        wb_en_i = 1'b0;
  logic [4:0]  wb_sel_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b1;
  logic [31:0] dec_pc_o, dec_rs1_val_o, dec_rs2_val_o, dec_imm_o;
  logic [4:0]  dec_rd_o;
  logic [3:0]  dec_op_o;
  logic [2:0]  dec_funct3_o;
  logic        dec_funct7b5_o, dec_illegal_o;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset_i(reset_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
    .rf_out1_sel_o(rf_out1_sel_o), .rf_out2_sel_o(rf_out2_sel_o),
    .rf_out1_i(rf_out1_i), .rf_out2_i(rf_out2_i),
    .wb_en_i(wb_en_i), .wb_sel_i(wb_sel_i), .wb_data_i(wb_data_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_rs1_val_o(dec_rs1_val_o), .dec_rs2_val_o(dec_rs2_val_o),
    .dec_imm_o(dec_imm_o), .dec_rd_o(dec_rd_o), .dec_op_o(dec_op_o),
    .dec_funct3_o(dec_funct3_o), .dec_funct7b5_o(dec_funct7b5_o),
    .dec_illegal_o(dec_illegal_o)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int handoffs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural register file with one-cycle synchronous read, read-before-write.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf_out1_i <= '0;
      rf_out2_i <= '0;
    end else begin
      rf_out1_i <= rf[rf_out1_sel_o];
      rf_out2_i <= rf[rf_out2_sel_o];
      if (wb_en_i && wb_sel_i != 5'd0) rf[wb_sel_i] <= wb_data_i;
    end
  end

  // Reference decode derived from the ISA encoding tables.
  task automatic model_dec(input logic [31:0] ins, output logic [3:0] op,
                           output logic [31:0] imm, output logic [4:0] rd);
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int v;
    rd  = ins[11:7];
    imm = '0;
    op  = 4'(CLS_ILLEGAL);
    case (ins[6:0])
      7'h37: begin op = 4'(CLS_LUI);   imm = ins & 32'hFFFF_F000; end
      7'h17: begin op = 4'(CLS_AUIPC); imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        op = 4'(CLS_JAL);
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        v = j21; imm = v;
      end
      7'h67: begin op = 4'(CLS_JALR);   v = $signed(ins) >>> 20; imm = v; end
      7'h63: begin
        op = 4'(CLS_BRANCH); rd = 0;
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        v = b13; imm = v;
      end
      7'h03: begin op = 4'(CLS_LOAD);   v = $signed(ins) >>> 20; imm = v; end
      7'h23: begin
        op = 4'(CLS_STORE); rd = 0;
        v = $signed(ins) >>> 25;
        imm = (v << 5) | {27'b0, ins[11:7]};
      end
      7'h13: begin op = 4'(CLS_OP_IMM); v = $signed(ins) >>> 20; imm = v; end
      7'h33: begin op = 4'(CLS_OP); end
      7'h0F: begin op = 4'(CLS_FENCE);  rd = 0; v = $signed(ins) >>> 20; imm = v; end
      7'h73: begin op = 4'(CLS_SYSTEM); v = $signed(ins) >>> 20; imm = v; end
      default: begin op = 4'(CLS_ILLEGAL); rd = 0; imm = '0; end
    endcase
  endtask

  // Transaction tracking: which instruction is held and whether it is still in its read cycle.
  logic        started = 1'b0;
  logic        have = 1'b0;
  logic        in_read = 1'b0;
  logic [31:0] cur_instr = '0;
  logic [31:0] cur_pc = '0;

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset_i && dec_valid_o && dec_ready_i) begin
      handoffs++;
      $display("xfer pc=%08h op=%0d rd=%0d rs1=%08h rs2=%08h imm=%08h ill=%0b",
               dec_pc_o, dec_op_o, dec_rd_o, dec_rs1_val_o, dec_rs2_val_o, dec_imm_o,
               dec_illegal_o);
    end
    if (reset_i || flush_i) begin
      have = 1'b0;
      in_read = 1'b0;
    end else begin
      if (have && !in_read && dec_ready_i) have = 1'b0;
      in_read = 1'b0;
      if (instr_valid_i && instr_ready_o) begin
        have = 1'b1;
        in_read = 1'b1;
        cur_instr = instr_i;
        cur_pc = pc_i;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0]  e_op;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic [4:0]  s1, s2;
    if (started) begin
      check("instr_ready", 32'(instr_ready_o),
            32'(!reset_i && !flush_i && (!have || (!in_read && dec_ready_i))));
      check("dec_valid", 32'(dec_valid_o), 32'(have && !in_read));
      if (dec_valid_o && have && !in_read) begin
        model_dec(cur_instr, e_op, e_imm, e_rd);
        s1 = cur_instr[19:15];
        s2 = cur_instr[24:20];
        check("m_pc", dec_pc_o, cur_pc);
        check("m_rs1", dec_rs1_val_o, (s1 == 5'd0) ? 32'h0 : rf[s1]);
        check("m_rs2", dec_rs2_val_o, (s2 == 5'd0) ? 32'h0 : rf[s2]);
        check("m_imm", dec_imm_o, e_imm);
        check("m_rd", 32'(dec_rd_o), 32'(e_rd));
        check("m_op", 32'(dec_op_o), 32'(e_op));
        check("m_funct3", 32'(dec_funct3_o), 32'(cur_instr[14:12]));
        check("m_f7b5", 32'(dec_funct7b5_o), 32'(cur_instr[30]));
        check("m_illegal", 32'(dec_illegal_o), 32'(e_op == 4'(CLS_ILLEGAL)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit ok = 0;
    instr_valid_i = 1'b1;
    instr_i = ins;
    pc_i = pc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready_o) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    step();
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dec_valid_o) begin ok = 1; break; end
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb(input logic en, input logic [4:0] sel, input logic [31:0] data);
    wb_en_i = en;
    wb_sel_i = sel;
    wb_data_i = data;
  endtask

  logic [31:0] b2b [8] = '{32'h00001517, 32'h008000EF, 32'h00512423, 32'h00812283,
                           32'h0FF0000F, 32'h00000073, 32'h00000000, 32'h40208233};

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", 32'(instr_ready_o), 32'd0);
    check("rst_valid", 32'(dec_valid_o), 32'd0);
    check("rst_pc", dec_pc_o, 32'h0);
    check("rst_imm", dec_imm_o, 32'h0);
    check("rst_rd", 32'(dec_rd_o), 32'd0);
    step();
    reset_i = 1'b0;

    // ADDI x5,x0,7
    dec_ready_i = 1'b1;
    send(32'h00700293, 32'h100);
    @(negedge clk);
    check("addi_read_novalid", 32'(dec_valid_o), 32'd0);
    @(negedge clk);
    check("addi_valid", 32'(dec_valid_o), 32'd1);
    check("addi_op", 32'(dec_op_o), 32'd7);
    check("addi_imm", dec_imm_o, 32'h00000007);
    check("addi_rd", 32'(dec_rd_o), 32'd5);
    check("addi_rs1", dec_rs1_val_o, 32'h0);
    check("addi_ready", 32'(instr_ready_o), 32'd1);
    step();

    // Preload x2, then ADD x3,x1,x2 with x1 written on the accept edge; stall in VALID
    wb(1'b1, 5'd2, 32'h11);
    step();
    wb(1'b1, 5'd1, 32'h12345678);
    dec_ready_i = 1'b0;
    send(32'h002081B3, 32'h104);
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("add_rs1", dec_rs1_val_o, 32'h12345678);
    check("add_rs2", dec_rs2_val_o, 32'h00000011);
    check("add_rd", 32'(dec_rd_o), 32'd3);
    check("add_op", 32'(dec_op_o), 32'd8);
    step();
    wb(1'b1, 5'd2, 32'hDEADBEEF);
    step();
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("stall_rs2", dec_rs2_val_o, 32'hDEADBEEF);
    check("stall_rs1", dec_rs1_val_o, 32'h12345678);
    check("stall_pc", dec_pc_o, 32'h104);
    check("stall_ready", 32'(instr_ready_o), 32'd0);
    check("stall_valid", 32'(dec_valid_o), 32'd1);
    step();
    dec_ready_i = 1'b1;
    step();

    // Read-edge write beats accept-edge write
    dec_ready_i = 1'b0;
    wb(1'b1, 5'd1, 32'hAAAA0001);
    send(32'h002081B3, 32'h108);
    wb(1'b1, 5'd1, 32'hBBBB0002);
    step();
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("prio_rs1", dec_rs1_val_o, 32'hBBBB0002);
    check("prio_rs2", dec_rs2_val_o, 32'hDEADBEEF);
    step();
    dec_ready_i = 1'b1;
    step();

    // Immediate forms and illegal opcode
    send(32'hFE000EE3, 32'h200);
    wait_valid();
    check("beq_imm", dec_imm_o, 32'hFFFFFFFC);
    check("beq_rd", 32'(dec_rd_o), 32'd0);
    step();
    send(32'h123453B7, 32'h204);
    wait_valid();
    check("lui_imm", dec_imm_o, 32'h12345000);
    check("lui_rd", 32'(dec_rd_o), 32'd7);
    step();
    send(32'hFFF100E7, 32'h208);
    wait_valid();
    check("jalr_imm", dec_imm_o, 32'hFFFFFFFF);
    check("jalr_rd", 32'(dec_rd_o), 32'd1);
    step();
    send(32'h0000007F, 32'h20C);
    wait_valid();
    check("ill_flag", 32'(dec_illegal_o), 32'd1);
    check("ill_op", 32'(dec_op_o), 32'd15);
    check("ill_rd", 32'(dec_rd_o), 32'd0);
    step();

    // Back-to-back stream, checked by the model only
    for (int i = 0; i < 8; i++) send(b2b[i], 32'h300 + 32'(4 * i));
    wait_valid();
    step();

    // Flush while VALID with a new instruction offered
    dec_ready_i = 1'b0;
    send(32'h00700293, 32'h400);
    wait_valid();
    step();
    instr_valid_i = 1'b1;
    instr_i = 32'h123453B7;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    @(negedge clk);
    check("flushv_valid0", 32'(dec_valid_o), 32'd0);
    @(negedge clk);
    check("flushv_valid1", 32'(dec_valid_o), 32'd0);
    @(negedge clk);
    check("flushv_valid2", 32'(dec_valid_o), 32'd0);

    // Flush while READ
    dec_ready_i = 1'b1;
    step();
    send(32'h00700293, 32'h404);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk);
    check("flushr_valid0", 32'(dec_valid_o), 32'd0);
    @(negedge clk);
    check("flushr_valid1", 32'(dec_valid_o), 32'd0);

    // Reset in the middle of a held bundle
    step();
    dec_ready_i = 1'b0;
    send(32'h123453B7, 32'h500);
    wait_valid();
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(dec_valid_o), 32'd0);
    check("mrst_pc", dec_pc_o, 32'h0);
    check("mrst_imm", dec_imm_o, 32'h0);
    check("mrst_rd", 32'(dec_rd_o), 32'd0);
    step();
    dec_ready_i = 1'b1;
    send(32'h00700293, 32'h600);
    wait_valid();
    check("recover_imm", dec_imm_o, 32'h00000007);
    step();

    repeat (2) step();
    check("handoff_count", 32'(handoffs), 32'd16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction decode stage sitting directly upstream of the register file. It accepts fetched RV32I instructions over a valid/ready handshake and drives the register-file read selects. It captures the read data, which has 1-cycle synchronous latency, and corrects stale operands by snooping the writeback port. It presents decoded fields, sign-extended immediate and operand values to the execute stage over a second valid/ready handshake.

Parameters:
XLEN, 32, data width; only 32 supported
FWD_EN, 1, 1 = writeback snoop/forwarding enabled; 0 = raw register-file data (bench-only)

Ports:
clk  in  1  clock
reset_i  in  1  synchronous active-high reset
instr_valid_i  in  1  fetch offers instruction
instr_ready_o  out  1  stage accepts instruction this edge
instr_i  in  32  instruction word
pc_i  in  32  instruction PC
flush_i  in  1  discard contents (branch redirect)
rf_out1_sel_o  out  5  register-file read select 1 (rs1)
rf_out2_sel_o  out  5  register-file read select 2 (rs2)
rf_out1_i  in  32  register-file read data 1 (valid cycle after select sampled)
rf_out2_i  in  32  register-file read data 2
wb_en_i  in  1  writeback enable (same signal feeding register file)
wb_sel_i  in  5  writeback register
wb_data_i  in  32  writeback data
dec_valid_o  out  1  decoded bundle valid
dec_ready_i  in  1  execute accepts bundle
dec_pc_o  out  32  PC
dec_rs1_val_o  out  32  rs1 operand
dec_rs2_val_o  out  32  rs2 operand
dec_imm_o  out  32  sign-extended immediate
dec_rd_o  out  5  destination; 0 if none
dec_op_o  out  4  op class (op_class_t)
dec_funct3_o  out  3  funct3
dec_funct7b5_o  out  1  instr[30]
dec_illegal_o  out  1  unsupported opcode

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset_i).
- Reset: state EMPTY. dec_valid_o=0, all dec_* outputs 0. instr_ready_o=0 while reset_i high.
- FSM states:
  - EMPTY: no instruction held.
  - READ: instruction latched; register-file data is present on rf_out*_i this cycle.
  - VALID: bundle presented to execute.
- instr_ready_o = !reset_i && !flush_i && (EMPTY || (VALID && dec_ready_i)).
- Accept occurs when instr_valid_i && instr_ready_o → latch instr/pc, next state READ.
- READ → VALID unconditionally; operands and decoded fields are captured into output registers.
- VALID && dec_ready_i && no accept → EMPTY. VALID && !dec_ready_i → hold all outputs stable.
- Throughput is 1 instruction per 2 cycles. dec_valid_o rises one cycle after the accept edge.
- Selects are combinational: instr_i[19:15]/[24:20] when instr_ready_o, else the latched fields.
- Forwarding (FWD_EN=1, never for reg 0; reg 0 operand always 0):
  - Write matching rs at the accept edge: the register file returns the old value, so latch wb_data_i and use it in READ.
  - Write matching rs at the READ→VALID edge: wb_data_i overrides. Priority is READ-edge write > accept-edge write > rf_out*_i.
  - Write matching rs while in VALID (stalled or at the handoff edge): update dec_rs*_val_o; all other fields unchanged.
- Decode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM.
  - Any other opcode (or instr[1:0]!=2'b11) → ILLEGAL, dec_illegal_o=1, dec_rd_o=0, dec_imm_o=0.
- Immediates are I/S/B/U/J per class and sign-extended from instr[31]. U form is instr[31:12]<<12.
- dec_rd_o is forced to 0 for BRANCH, STORE, FENCE.
- flush_i: next state EMPTY, dec_valid_o=0 next cycle. Takes priority over accept and over a READ→VALID transition. Data outputs need not clear.
- Reset mid-operation: identical to flush, plus outputs zeroed.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams
  - op_class_t (4-bit enum, including ILLEGAL)
  - imm_fmt_t (I, S, B, U, J, NONE)
  - state_t
- Sub-module imm_gen is purely combinational: (instr, imm_fmt_t) → 32-bit immediate.

Test Plan:
- Reset, then ADDI x5,x0,7 (0x00700293), dec_ready_i=1 → one cycle after accept: dec_valid_o=1, op OP_IMM, imm 0x00000007, rd 5, rs1_val 0; instr_ready_o=1 that same cycle.
- Preload x2=0x11; accept ADD x3,x1,x2 (0x002081B3) on the same edge as wb x1=0x12345678 → rs1_val 0x12345678, rs2_val 0x00000011, rd 3, op OP.
- Hold dec_ready_i=0 for 5 cycles in VALID. Write x2=0xDEADBEEF, then x0=0xFFFFFFFF → rs2_val becomes 0xDEADBEEF, the x0 write is ignored, other outputs stable, instr_ready_o=0 throughout.
- Immediates:
  - BEQ x0,x0,-4 (0xFE000EE3) → imm 0xFFFFFFFC, rd 0.
  - LUI x7,0x12345 (0x123453B7) → imm 0x12345000.
  - JALR x1,-1(x2) (0xFFF100E7) → imm 0xFFFFFFFF.
- Instruction 0x0000007F → dec_illegal_o=1, op ILLEGAL, rd 0.
- flush_i asserted in VALID with instr_valid_i=1 → dec_valid_o=0 next cycle, no instruction accepted. Also assert flush_i in READ → no bundle emitted.
